// File: rtl/mem_arbiter_pkg.sv
// Shared defaults for the arbitrated memory block and the helper that sizes port indices.
package mem_arbiter_pkg;

   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 1024;

   // A single-port configuration still needs a one-bit index.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_ram_core.sv
// Single-port word store: synchronous write, registered read, out-of-range accesses neutralised.
module ram_core
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              in_range;

   assign in_range = ({1'b0, addr} < DEPTH_L);

   // NOTE: the array has no reset branch; clearing every word would turn it into flops.
   always_ff @(posedge clk) begin
      if (en && we && in_range)
         mem[addr] <= wdata;
   end

   // Only the output register is reset; it holds between reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rdata <= '0;
      else if (en && !we)
         rdata <= in_range ? mem[addr] : '0;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of NPORTS requesters per cycle access to a shared ram_core.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int NPORTS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORTS-1:0]        req,
   input  logic [NPORTS-1:0]        we,
   input  logic [NPORTS*ADDR_W-1:0] addr,
   input  logic [NPORTS*DATA_W-1:0] wdata,
   output logic [NPORTS-1:0]        gnt,
   output logic [NPORTS-1:0]        rvalid,
   output logic [DATA_W-1:0]        rdata
);

   localparam int PW = idx_w(NPORTS);

   logic [PW-1:0]     last;
   logic [PW-1:0]     sel;
   logic              found;
   int                cand;
   logic              accept;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
   always_comb begin
      gnt   = '0;
      sel   = '0;
      found = 1'b0;
      cand  = 0;
      for (int i = 1; i <= NPORTS; i++) begin
         cand = (int'(last) + i) % NPORTS;
         if (!found && rst && req[cand]) begin
            gnt[cand] = 1'b1;
            sel       = PW'(cand);
            found     = 1'b1;
         end
      end
   end

   assign accept    = found;
   assign sel_we    = we[sel];
   assign sel_addr  = addr[int'(sel)*ADDR_W +: ADDR_W];
   assign sel_wdata = wdata[int'(sel)*DATA_W +: DATA_W];

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last   <= PW'(NPORTS - 1);
         rvalid <= '0;
      end else begin
         if (accept)
            last <= sel;
         rvalid <= (accept && !sel_we) ? gnt : '0;
      end
   end

   ram_core #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .en    (accept),
      .we    (sel_we),
      .addr  (sel_addr),
      .wdata (sel_wdata),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two-port scoreboarded instance plus four-port and one-port grant checks.
module tb_mem_arbiter;

   typedef struct packed {
      logic [1:0]  port;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [1:0]  req = '0, we = '0;
   logic [19:0] addr = '0;
   logic [63:0] wdata = '0;
   logic [1:0]  gnt, rvalid;
   logic [31:0] rdata;

   logic [3:0]   req4 = '0, we4 = '0;
   logic [39:0]  addr4 = '0;
   logic [127:0] wdata4 = '0;
   logic [3:0]   gnt4, rvalid4;
   logic [31:0]  rdata4;

   logic [0:0]  req1 = '0, we1 = '0;
   logic [9:0]  addr1 = '0;
   logic [31:0] wdata1 = '0;
   logic [0:0]  gnt1, rvalid1;
   logic [31:0] rdata1;

   int checks = 0;
   int errors = 0;

   exp_t        sb [$];
   exp_t        mon_e;
   logic [31:0] model [0:999];

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(10), .DEPTH(1000), .DATA_W(32), .NPORTS(2)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
   );

   mem_arbiter #(.ADDR_W(10), .DEPTH(1024), .DATA_W(32), .NPORTS(4)) dut4 (
      .clk(clk), .rst(rst), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
      .gnt(gnt4), .rvalid(rvalid4), .rdata(rdata4)
   );

   mem_arbiter #(.ADDR_W(10), .DEPTH(1024), .DATA_W(32), .NPORTS(1)) dut1 (
      .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
      .gnt(gnt1), .rvalid(rvalid1), .rdata(rdata1)
   );

   // Response monitor: one expected entry per accepted read, due right after the accepting edge.
   always @(posedge clk) begin
      #1;
      checks++;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         if (rvalid !== mon_e.port || rdata !== mon_e.data) begin
            errors++;
            $display("FAIL response: rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                     rvalid, rdata, mon_e.port, mon_e.data);
         end
      end else if (rvalid !== 2'b00) begin
         errors++;
         $display("FAIL spurious_rvalid: rvalid=%b expected 00", rvalid);
      end
   end

   task automatic drive(input logic [1:0] r, input logic [1:0] w,
                        input logic [9:0] a1, input logic [9:0] a0,
                        input logic [31:0] d1, input logic [31:0] d0);
      @(negedge clk);
      req   = r;
      we    = w;
      addr  = {a1, a0};
      wdata = {d1, d0};
   endtask

   // Applies the expected grant to the reference memory and queues any read response.
   task automatic commit(input logic [1:0] g);
      logic [9:0] a;
      exp_t       e;
      for (int p = 0; p < 2; p++) begin
         if (g[p]) begin
            a = addr[p*10 +: 10];
            if (we[p]) begin
               if (a < 10'd1000) model[a] = wdata[p*32 +: 32];
            end else begin
               e.port = g;
               e.data = (a < 10'd1000) ? model[a] : 32'h0;
               sb.push_back(e);
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      req = 2'b11;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({gnt, rvalid, rdata} !== 36'h0) begin
            errors++;
            $display("FAIL reset_hold: gnt=%b rvalid=%b rdata=%h expected all zero", gnt, rvalid, rdata);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL reset_first_grant: gnt=%b expected 01", gnt);
      end
      req = 2'b00;
      #1;
      checks++;
      if (gnt !== 2'b00) begin
         errors++;
         $display("FAIL no_req_no_gnt: gnt=%b expected 00", gnt);
      end
   endtask

   task automatic test_write_read;
      drive(2'b01, 2'b01, 10'd0, 10'd5, 32'h0, 32'hDEADBEEF);
      #1;
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL wr_gnt: gnt=%b expected 01", gnt);
      end
      commit(2'b01);
      drive(2'b01, 2'b00, 10'd0, 10'd5, 32'h0, 32'h0);
      #1;
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL rd_gnt: gnt=%b expected 01", gnt);
      end
      commit(2'b01);
      drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
      #1;
      checks++;
      if (rvalid !== 2'b01 || rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_data: rvalid=%b rdata=%h expected 01 deadbeef", rvalid, rdata);
      end
      drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
      #1;
      checks++;
      if (rvalid !== 2'b00 || rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL rd_hold: rvalid=%b rdata=%h expected 00 deadbeef", rvalid, rdata);
      end
   endtask

   task automatic test_fairness;
      logic [1:0] seq [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
      drive(2'b01, 2'b01, 10'd0, 10'd10, 32'h0, 32'hA0A00010);
      #1;
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL fair_wr0: gnt=%b expected 01", gnt);
      end
      commit(2'b01);
      drive(2'b10, 2'b10, 10'd11, 10'd0, 32'hB1B10011, 32'h0);
      #1;
      checks++;
      if (gnt !== 2'b10) begin
         errors++;
         $display("FAIL fair_wr1: gnt=%b expected 10", gnt);
      end
      commit(2'b10);
      for (int i = 0; i < 6; i++) begin
         drive(2'b11, 2'b00, 10'd11, 10'd10, 32'h0, 32'h0);
         #1;
         checks++;
         if (gnt !== seq[i]) begin
            errors++;
            $display("FAIL fair_gnt[%0d]: gnt=%b expected %b", i, gnt, seq[i]);
         end
         commit(seq[i]);
      end
      drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
   endtask

   task automatic test_back_to_back;
      drive(2'b10, 2'b10, 10'd20, 10'd0, 32'hC0FFEE20, 32'h0);
      #1;
      checks++;
      if (gnt !== 2'b10) begin
         errors++;
         $display("FAIL b2b_wr: gnt=%b expected 10", gnt);
      end
      commit(2'b10);
      drive(2'b01, 2'b00, 10'd0, 10'd20, 32'h0, 32'h0);
      #1;
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL b2b_rd: gnt=%b expected 01", gnt);
      end
      commit(2'b01);
      drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
   endtask

   task automatic test_out_of_range;
      logic [9:0]  a_tab [5] = '{10'd999, 10'd1000, 10'd1023, 10'd1000, 10'd999};
      logic        w_tab [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] d_tab [5] = '{32'hCAFEF00D, 32'h12345678, 32'hDEADDEAD, 32'h0, 32'h0};
      for (int i = 0; i < 5; i++) begin
         drive(2'b01, {1'b0, w_tab[i]}, 10'd0, a_tab[i], 32'h0, d_tab[i]);
         #1;
         checks++;
         if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL oor_gnt[%0d]: gnt=%b expected 01", i, gnt);
         end
         commit(2'b01);
      end
      drive(2'b00, 2'b00, 10'd0, 10'd0, 32'h0, 32'h0);
      #1;
      checks++;
      if (rdata !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL oor_word999: rdata=%h expected cafef00d", rdata);
      end
   endtask

   task automatic test_mid_reset;
      drive(2'b01, 2'b01, 10'd0, 10'd3, 32'h0, 32'h33333333);
      commit(2'b01);
      drive(2'b01, 2'b00, 10'd0, 10'd3, 32'h0, 32'h0);
      commit(2'b01);
      @(negedge clk);
      rst = 1'b0;
      req = 2'b00;
      #1;
      checks++;
      if ({gnt, rvalid, rdata} !== 36'h0) begin
         errors++;
         $display("FAIL rst_discard: gnt=%b rvalid=%b rdata=%h expected all zero", gnt, rvalid, rdata);
      end
      @(negedge clk);
      rst = 1'b1;
      drive(2'b01, 2'b00, 10'd0, 10'd3, 32'h0, 32'h0);
      #1;
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL rst_regrant: gnt=%b expected 01", gnt);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({gnt, rvalid, rdata} !== 36'h0) begin
         errors++;
         $display("FAIL rst_pre_edge: gnt=%b rvalid=%b rdata=%h expected all zero", gnt, rvalid, rdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if (rvalid !== 2'b00 || rdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_after_edge: rvalid=%b rdata=%h expected 00 0", rvalid, rdata);
      end
      req = 2'b00;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_quad;
      logic [3:0] alt [6] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000, 4'b0010, 4'b1000};
      logic [3:0] all [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      @(negedge clk);
      req4 = 4'b1010;
      we4  = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (gnt4 !== alt[i] || rvalid4 !== 4'b0000) begin
            errors++;
            $display("FAIL quad_alt[%0d]: gnt=%b rvalid=%b expected %b 0000", i, gnt4, rvalid4, alt[i]);
         end
         @(negedge clk);
      end
      req4 = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (gnt4 !== all[i]) begin
            errors++;
            $display("FAIL quad_all[%0d]: gnt=%b expected %b", i, gnt4, all[i]);
         end
         @(negedge clk);
      end
      req4 = 4'b0000;
   endtask

   task automatic test_single;
      @(negedge clk);
      req1   = 1'b1;
      we1    = 1'b1;
      addr1  = 10'd7;
      wdata1 = 32'h00000077;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt[%0d]: gnt=%b expected 1", i, gnt1);
         end
         @(negedge clk);
      end
      we1 = 1'b0;
      @(negedge clk);
      req1 = 1'b0;
      #1;
      checks++;
      if (rvalid1 !== 1'b1 || rdata1 !== 32'h00000077 || gnt1 !== 1'b0) begin
         errors++;
         $display("FAIL single_read: gnt=%b rvalid=%b rdata=%h expected 0 1 00000077", gnt1, rvalid1, rdata1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_fairness();
      test_back_to_back();
      test_out_of_range();
      test_mid_reset();
      test_quad();
      test_single();
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d responses outstanding, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, address width in words.
REQ-002 Parameter DEPTH, default 1024, number of words stored; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-003 Parameter DATA_W, default 32, word width.
REQ-004 Parameter NPORTS, default 2, number of requester ports; SHALL be >= 1.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 req  input  NPORTS  per-port request, bit p = port p.
REQ-008 we  input  NPORTS  per-port write enable; 1 = write, 0 = read.
REQ-009 addr  input  NPORTS*ADDR_W  per-port address; port p at bits [p*ADDR_W +: ADDR_W].
REQ-010 wdata  input  NPORTS*DATA_W  per-port write data, packed the same way.
REQ-011 gnt  output  NPORTS  one-hot grant, combinational from req and the arbitration pointer.
REQ-012 rvalid  output  NPORTS  read data valid for port p, registered.
REQ-013 rdata  output  DATA_W  shared read data bus, registered; meaningful only while some rvalid bit is 1.

Function
REQ-014 At most one gnt bit SHALL be 1 per cycle; gnt SHALL be all-zero when req is all-zero.
REQ-015 Arbitration SHALL be round-robin: search starts at port (last+1) mod NPORTS and grants the first requesting port.
REQ-016 On each edge with a grant, "last" SHALL update to the granted port index; with no grant, "last" SHALL hold.
REQ-017 A request is accepted on the edge where req[p] and gnt[p] are both 1; a requester SHALL hold req, we, addr and wdata stable until accepted.
REQ-018 Accepted write: the word at addr[p] SHALL be updated at the accepting edge; rvalid stays 0 for that port.
REQ-019 Accepted read: rdata SHALL carry the word at addr[p] and rvalid[p] SHALL be 1 in the cycle after the accepting edge (latency 1); all other rvalid bits 0.
REQ-020 rvalid SHALL deassert in the next cycle unless a new read is accepted.
REQ-021 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-022 With NPORTS = 1, the single port SHALL be granted whenever req[0] = 1.
REQ-023 Write with addr >= DEPTH SHALL be dropped without modifying memory; read with addr >= DEPTH SHALL return rdata = 0 with rvalid asserted normally.
REQ-024 With two or more ports requesting continuously, each SHALL be granted at least once every NPORTS cycles (no starvation).
REQ-025 When no read is accepted, rdata SHALL hold its previous value.

Reset
REQ-026 While rst = 0: rvalid = 0, rdata = 0, last = NPORTS-1 (port 0 wins first after reset), gnt = 0.
REQ-027 Reset asserted mid-transaction SHALL discard any pending read response; memory contents SHALL NOT be reset or guaranteed.
REQ-028 First acceptance SHALL occur no earlier than the first rising edge after rst deasserts.

Structure
REQ-029 A shared package SHALL hold default values of ADDR_W, DATA_W, DEPTH and the port-index width function clog2(NPORTS) (minimum 1).
REQ-030 Storage SHALL be a separate sub-module, ram_core (single-port, synchronous write, registered read, parameters ADDR_W/DATA_W/DEPTH); arbitration and response steering stay in mem_arbiter.

Verification
REQ-031 Reset: hold rst = 0 for 10 cycles with req = 2'b11 -> gnt = 0, rvalid = 0, rdata = 0; after release port 0 is granted first.
REQ-032 Write/read: port 0 writes 0xDEADBEEF to addr 5, next cycle reads addr 5 -> one cycle later rvalid = 2'b01, rdata = 0xDEADBEEF.
REQ-033 Fairness: req = 2'b11 held for 6 cycles of reads -> grants alternate 01,10,01,10,01,10; rvalid follows one cycle later.
REQ-034 Out-of-range (DEPTH = 1000): write 0x12345678 to addr 1000, then read addr 1000 -> rdata = 0; memory word 999 unchanged.
REQ-035 Mid-read reset: accept read at addr 3, assert rst before the next edge -> rvalid stays 0 and rdata = 0 in the following cycle.
REQ-036 NPORTS = 4, ports 1 and 3 requesting -> grants alternate port 1, port 3; ports 0 and 2 never granted.
